// File: rtl/cordic_phase_gen.sv
// Phase-accumulator feeder for the pipelined sine/cosine CORDIC rotator.
// Issues angle/x_start/y_start samples in bursts (or continuously) and
// tracks rotator output validity with a latency-matched valid delay line.
module cordic_phase_gen #(
    parameter int unsigned width   = 16,
    parameter int unsigned LATENCY = 16,
    parameter int unsigned AMP     = 19000
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    cfg_we,
    input  logic [31:0]             freq_word,
    input  logic [31:0]             phase_offset,
    input  logic [15:0]             sample_count,
    input  logic                    start,
    input  logic                    stop,
    output logic [31:0]             angle,
    output logic signed [width-1:0] x_start,
    output logic signed [width-1:0] y_start,
    output logic                    in_valid,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;
    // Delay taps ahead of the out_valid flop; together they form LATENCY stages.
    localparam int unsigned DW = LATENCY - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [AW-1:0]           freq_q,      freq_d;
    logic [AW-1:0]           offset_q,    offset_d;
    logic [CW-1:0]           count_q,     count_d;
    logic [CW-1:0]           remaining_q, remaining_d;
    logic [AW-1:0]           acc_q,       acc_d;
    logic [AW-1:0]           angle_q,     angle_d;
    logic signed [width-1:0] x_start_q,   x_start_d;
    logic signed [width-1:0] y_start_q,   y_start_d;
    logic                    in_valid_q,  in_valid_d;
    logic [DW-1:0]           dly_q,       dly_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // Next-state, accumulator, config latch and output computation.
    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        offset_d    = offset_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        angle_d     = angle_q;
        x_start_d   = '0;
        y_start_d   = '0;
        in_valid_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dly_d       = DW'({dly_q, in_valid_q});
        out_valid_d = dly_q[DW-1];

        case (state_q)
            S_IDLE: begin
                angle_d = '0;
                busy_d  = 1'b0;
                if (cfg_we) begin
                    freq_d   = freq_word;
                    offset_d = phase_offset;
                    count_d  = sample_count;
                end
                if (start && !stop) begin
                    acc_d       = '0;
                    remaining_d = count_q;
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (stop) begin
                    state_d = S_DRAIN;
                end else begin
                    angle_d    = acc_q + offset_q;
                    acc_d      = acc_q + freq_q;
                    in_valid_d = 1'b1;
                    x_start_d  = width'(AMP);
                    // remaining of zero means continuous; it never counts down.
                    if (remaining_q == CW'(1)) begin
                        state_d = S_DRAIN;
                    end else if (remaining_q != '0) begin
                        remaining_d = remaining_q - CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                busy_d = 1'b1;
                // Leave once the whole delay line (including out_valid) will be empty.
                if ((dly_q == '0) && !in_valid_q) begin
                    state_d = S_IDLE;
                    angle_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            freq_q      <= '0;
            offset_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            acc_q       <= '0;
            angle_q     <= '0;
            x_start_q   <= '0;
            y_start_q   <= '0;
            in_valid_q  <= 1'b0;
            dly_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            offset_q    <= offset_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            angle_q     <= angle_d;
            x_start_q   <= x_start_d;
            y_start_q   <= y_start_d;
            in_valid_q  <= in_valid_d;
            dly_q       <= dly_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign angle     = angle_q;
    assign x_start   = x_start_q;
    assign y_start   = y_start_q;
    assign in_valid  = in_valid_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: bursts, wrap/offset, continuous+stop,
// ignored inputs and asynchronous reset mid-burst.
module tb_cordic_phase_gen;

    logic               clock = 1'b0;
    logic               nreset;
    logic               cfg_we;
    logic [31:0]        freq_word;
    logic [31:0]        phase_offset;
    logic [15:0]        sample_count;
    logic               start;
    logic               stop;
    logic [31:0]        angle;
    logic signed [15:0] x_start;
    logic signed [15:0] y_start;
    logic               in_valid;
    logic               out_valid;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cordic_phase_gen #(
        .width  (16),
        .LATENCY(16),
        .AMP    (19000)
    ) dut (
        .clock       (clock),
        .nreset      (nreset),
        .cfg_we      (cfg_we),
        .freq_word   (freq_word),
        .phase_offset(phase_offset),
        .sample_count(sample_count),
        .start       (start),
        .stop        (stop),
        .angle       (angle),
        .x_start     (x_start),
        .y_start     (y_start),
        .in_valid    (in_valid),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done)
    );

    // Stimulus helpers: called just after a falling edge.
    task automatic do_cfg(input logic [31:0] f, input logic [31:0] o, input logic [15:0] n);
        cfg_we = 1'b1; freq_word = f; phase_offset = o; sample_count = n;
        @(negedge clock);
        cfg_we = 1'b0; freq_word = '0; phase_offset = '0; sample_count = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [70:0] outs;
        nreset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'($urandom()); freq_word = $urandom(); phase_offset = $urandom();
            sample_count = 16'($urandom()); start = 1'($urandom()); stop = 1'($urandom());
            @(negedge clock);
            outs = {angle, x_start, y_start, in_valid, out_valid, busy, done};
            n_tests++;
            if (outs !== '0) begin
                n_fail++; $display("FAIL reset_hold[%0d]: got %h expected 0", i, outs);
            end
        end
        cfg_we = 0; freq_word = 0; phase_offset = 0; sample_count = 0; start = 0; stop = 0;
        nreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            outs = {angle, x_start, y_start, in_valid, out_valid, busy, done};
            n_tests++;
            if (outs !== '0) begin
                n_fail++; $display("FAIL reset_release[%0d]: got %h expected 0", i, outs);
            end
        end
    endtask

    task automatic test_finite_burst();
        logic        e_iv, e_ov, e_done, e_busy;
        logic [31:0] e_ang;
        logic signed [15:0] e_x;
        do_cfg(32'h4000_0000, 32'h0, 16'd4);
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || in_valid !== 1'b0) begin
            n_fail++; $display("FAIL burst_start: busy=%b in_valid=%b expected 1/0", busy, in_valid);
        end
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            e_iv   = (k <= 4);
            e_ov   = (k >= 17 && k <= 20);
            e_done = (k == 21);
            e_busy = (k <= 20);
            e_ang  = (k <= 4) ? 32'(k - 1) * 32'h4000_0000 : ((k <= 20) ? 32'hC000_0000 : 32'h0);
            e_x    = e_iv ? 16'sd19000 : 16'sd0;
            n_tests++;
            if (in_valid !== e_iv || out_valid !== e_ov || done !== e_done || busy !== e_busy) begin
                n_fail++;
                $display("FAIL burst_flags k=%0d: iv/ov/done/busy=%b%b%b%b expected %b%b%b%b",
                         k, in_valid, out_valid, done, busy, e_iv, e_ov, e_done, e_busy);
            end
            n_tests++;
            if (angle !== e_ang || x_start !== e_x || y_start !== 16'sd0) begin
                n_fail++;
                $display("FAIL burst_data k=%0d: angle=%h x=%0d y=%0d expected %h %0d 0",
                         k, angle, x_start, y_start, e_ang, e_x);
            end
        end
    endtask

    task automatic test_wrap_offset();
        logic [31:0] e_ang [3];
        int n_done;
        e_ang[0] = 32'h2000_0000; e_ang[1] = 32'hA000_0000; e_ang[2] = 32'h2000_0000;
        do_cfg(32'h8000_0000, 32'h2000_0000, 16'd3);
        pulse_start();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            n_tests++;
            if (in_valid !== 1'b1 || angle !== e_ang[k-1]) begin
                n_fail++; $display("FAIL wrap_angle k=%0d: iv=%b angle=%h expected 1 %h",
                                   k, in_valid, angle, e_ang[k-1]);
            end
        end
        @(negedge clock);
        n_tests++;
        if (in_valid !== 1'b0 || angle !== 32'h2000_0000 || x_start !== 16'sd0) begin
            n_fail++; $display("FAIL wrap_drain_hold: iv=%b angle=%h x=%0d expected 0 20000000 0",
                               in_valid, angle, x_start);
        end
        n_done = 0;
        for (int k = 5; k <= 25; k++) begin
            @(negedge clock);
            if (done === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done != 1) begin
            n_fail++; $display("FAIL wrap_done_count: got %0d expected 1", n_done);
        end
    endtask

    task automatic test_continuous_stop();
        int n_iv, n_ov, n_done;
        do_cfg(32'h1, 32'h0, 16'd0);
        pulse_start();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            n_tests++;
            if (in_valid !== 1'b1 || angle !== 32'(k - 1)) begin
                n_fail++; $display("FAIL cont_angle k=%0d: iv=%b angle=%h expected 1 %h",
                                   k, in_valid, angle, 32'(k - 1));
            end
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_tests++;
        if (in_valid !== 1'b0 || angle !== 32'd9 || busy !== 1'b1) begin
            n_fail++; $display("FAIL cont_stop: iv=%b angle=%h busy=%b expected 0 9 1",
                               in_valid, angle, busy);
        end
        n_iv = 0; n_ov = 0; n_done = 0;
        for (int k = 12; k <= 40; k++) begin
            @(negedge clock);
            if (in_valid === 1'b1) n_iv++;
            if (out_valid === 1'b1) n_ov++;
            if (done === 1'b1) n_done++;
        end
        n_tests++;
        if (n_iv != 0 || n_ov != 10 || n_done != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cont_drain: iv=%0d ov=%0d done=%0d busy=%b expected 0 10 1 0",
                               n_iv, n_ov, n_done, busy);
        end
    endtask

    task automatic test_ignored_inputs();
        int n_done;
        start = 1'b1; stop = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || in_valid !== 1'b0) begin
            n_fail++; $display("FAIL start_stop_idle: busy=%b iv=%b expected 0 0", busy, in_valid);
        end
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || in_valid !== 1'b0) begin
            n_fail++; $display("FAIL start_stop_idle2: busy=%b iv=%b expected 0 0", busy, in_valid);
        end
        do_cfg(32'h1000_0000, 32'h0, 16'd4);
        pulse_start();
        @(negedge clock);
        cfg_we = 1'b1; freq_word = 32'h7000_0000; phase_offset = 32'h5; sample_count = 16'd2;
        @(negedge clock);
        cfg_we = 1'b0; freq_word = 0; phase_offset = 0; sample_count = 0;
        for (int k = 2; k <= 4; k++) begin
            n_tests++;
            if (angle !== 32'(k - 1) * 32'h1000_0000 || in_valid !== 1'b1) begin
                n_fail++; $display("FAIL cfg_in_run k=%0d: angle=%h iv=%b expected %h 1",
                                   k, angle, in_valid, 32'(k - 1) * 32'h1000_0000);
            end
            @(negedge clock);
        end
        n_done = 0;
        for (int k = 5; k <= 25; k++) begin
            @(negedge clock);
            if (done === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done != 1) begin
            n_fail++; $display("FAIL cfg_in_run_done: got %0d expected 1", n_done);
        end
        pulse_start();
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (angle !== 32'h1000_0000) begin
            n_fail++; $display("FAIL cfg_retained: angle=%h expected 10000000", angle);
        end
        repeat (25) @(negedge clock);
    endtask

    task automatic test_reset_mid_burst();
        logic [70:0] outs;
        int n_iv, n_ov, n_done;
        do_cfg(32'h0100_0000, 32'h1234_5678, 16'd8);
        pulse_start();
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (angle !== 32'h1334_5678 || in_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_sample2: angle=%h iv=%b expected 13345678 1", angle, in_valid);
        end
        nreset = 1'b0;
        #1;
        outs = {angle, x_start, y_start, in_valid, out_valid, busy, done};
        n_tests++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL midrst_async: got %h expected 0", outs);
        end
        @(negedge clock);
        @(negedge clock);
        nreset = 1'b1;
        n_iv = 0; n_ov = 0; n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (in_valid === 1'b1) n_iv++;
            if (out_valid === 1'b1) n_ov++;
            if (done === 1'b1) n_done++;
        end
        n_tests++;
        if (n_iv != 0 || n_ov != 0 || n_done != 0) begin
            n_fail++; $display("FAIL midrst_quiet: iv=%0d ov=%0d done=%0d expected 0 0 0", n_iv, n_ov, n_done);
        end
        do_cfg(32'h0100_0000, 32'h1234_5678, 16'd8);
        pulse_start();
        @(negedge clock);
        n_tests++;
        if (angle !== 32'h1234_5678 || in_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_restart: angle=%h iv=%b expected 12345678 1", angle, in_valid);
        end
        n_ov = 0; n_done = 0;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clock);
            if (out_valid === 1'b1) n_ov++;
            if (done === 1'b1) n_done++;
        end
        n_tests++;
        if (n_ov != 8 || n_done != 1) begin
            n_fail++; $display("FAIL midrst_restart_drain: ov=%0d done=%0d expected 8 1", n_ov, n_done);
        end
    endtask

    initial begin
        nreset = 1'b0; cfg_we = 0; freq_word = 0; phase_offset = 0;
        sample_count = 0; start = 0; stop = 0;
        @(negedge clock);
        test_reset();
        test_finite_burst();
        test_wrap_offset();
        test_continuous_stop();
        test_ignored_inputs();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
